// File: rtl/disp_timing_pkg.sv
// ============================================================================
// Module      : disp_timing_pkg
// Description : Default raster timing and BT.601 colour-bar table for the
//               micro-display timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_SYNC   = 62;
    localparam int DEF_H_BP     = 60;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 96;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 30;
    localparam int DEF_V_ACTIVE = 400;
    localparam int DEF_V_FP     = 89;

    localparam int H_TOTAL     = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
    localparam int V_TOTAL     = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;
    localparam int H_ACT_START = DEF_H_SYNC + DEF_H_BP;
    localparam int V_ACT_START = DEF_V_SYNC + DEF_V_BP;

    localparam logic [15:0] GREY_PIX  = 16'h8080;
    localparam logic [15:0] BLACK_PIX = 16'h1080;

    // Bar 0 (white) sits in the least significant byte, bar 7 (black) in the top.
    localparam logic [7:0][7:0] BAR_Y  = {8'd16,  8'd41,  8'd81,  8'd106,
                                          8'd145, 8'd170, 8'd210, 8'd235};
    localparam logic [7:0][7:0] BAR_CB = {8'd128, 8'd240, 8'd90,  8'd202,
                                          8'd54,  8'd166, 8'd16,  8'd128};
    localparam logic [7:0][7:0] BAR_CR = {8'd128, 8'd110, 8'd240, 8'd222,
                                          8'd34,  8'd16,  8'd146, 8'd128};

    function automatic logic [15:0] bar_pixel(input logic [2:0] idx, input logic odd);
        return {BAR_Y[idx], (odd ? BAR_CR[idx] : BAR_CB[idx])};
    endfunction

endpackage

`default_nettype wire

// File: rtl/disp_pattern_gen.sv
// ============================================================================
// Module      : disp_pattern_gen
// Description : Active-video column tracking and colour-bar / grey pixel mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_pattern_gen
    import disp_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        active,
    input  logic        disp_bars,
    input  logic        disp_grey,
    output logic [15:0] data
);

    localparam int               c_bar_w    = H_ACTIVE / 8;
    localparam logic [CNT_W-1:0] c_bar_last = CNT_W'(c_bar_w - 1);

    logic [CNT_W-1:0] r_bar_px;
    logic [2:0]       r_bar_idx;
    logic             r_px_odd;
    logic [15:0]      w_pix;

    always_comb begin
        w_pix = '0;
        if (active) begin
            if (disp_bars)
                w_pix = bar_pixel(r_bar_idx, r_px_odd);
            else if (disp_grey)
                w_pix = GREY_PIX;
            else
                w_pix = BLACK_PIX;
        end
    end

    // Column position is kept as a bar index plus offset so no divider is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
            r_px_odd  <= 1'b0;
            data      <= '0;
        end else if (!enable || !active) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
            r_px_odd  <= 1'b0;
            data      <= '0;
        end else begin
            r_px_odd <= ~r_px_odd;
            data     <= w_pix;
            if (r_bar_px == c_bar_last) begin
                r_bar_px  <= '0;
                r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_px <= r_bar_px + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/disp_timing_gen.sv
// ============================================================================
// Module      : disp_timing_gen
// Description : Free-running raster timing generator with registered syncs,
//               data enable and built-in test pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_timing_gen
    import disp_timing_pkg::*;
#(
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        disp_grey,
    input  logic        disp_bars,
    output logic [15:0] data,
    output logic        hs_n,
    output logic        vs_n,
    output logic        de
);

    localparam int c_h_total = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int c_v_total = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CNT_W-1:0] c_h_last      = CNT_W'(c_h_total - 1);
    localparam logic [CNT_W-1:0] c_v_last      = CNT_W'(c_v_total - 1);
    localparam logic [CNT_W-1:0] c_h_sync      = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] c_v_sync      = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] c_h_act_start = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] c_h_act_end   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] c_v_act_start = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] c_v_act_end   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_hs_n;
    logic             w_vs_n;
    logic             w_active;

    always_comb begin
        w_h_wrap = (r_h_cnt == c_h_last);
        w_v_wrap = (r_v_cnt == c_v_last);
        w_hs_n   = !(r_h_cnt < c_h_sync);
        w_vs_n   = !(r_v_cnt < c_v_sync);
        w_active = (r_h_cnt >= c_h_act_start) && (r_h_cnt < c_h_act_end) &&
                   (r_v_cnt >= c_v_act_start) && (r_v_cnt < c_v_act_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!enable) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // Outputs lag the counters by one clock so the first enabled edge shows (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_n <= 1'b1;
            vs_n <= 1'b1;
            de   <= 1'b0;
        end else begin
            hs_n <= enable ? w_hs_n : 1'b1;
            vs_n <= enable ? w_vs_n : 1'b1;
            de   <= enable & w_active;
        end
    end

    disp_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .active    (w_active),
        .disp_bars (disp_bars),
        .disp_grey (disp_grey),
        .data      (data)
    );

endmodule

`default_nettype wire

// File: tb/tb_disp_timing_gen.sv
// ============================================================================
// Module      : tb_disp_timing_gen
// Description : Directed self-checking bench for disp_timing_gen, using full
//               horizontal timing and a shortened vertical frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_disp_timing_gen;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        enable    = 1'b0;
    logic        disp_grey = 1'b0;
    logic        disp_bars = 1'b0;
    logic [15:0] data;
    logic        hs_n;
    logic        vs_n;
    logic        de;

    int n_cmp = 0;
    int n_mis = 0;

    int   edge_n, de_cnt, de_lines, first_de_edge, vs_low, bad_idle, grey_bad, px, n;
    logic prev_de;
    bit   cap_en, grey_mode;
    logic [15:0] pix [0:639];

    always #5 clk = ~clk;

    // V timing: 2 sync + 3 bp + 4 active + 2 fp = 11 lines; active starts at line 5.
    disp_timing_gen #(
        .H_SYNC   (62),
        .H_BP     (60),
        .H_ACTIVE (640),
        .H_FP     (96),
        .V_SYNC   (2),
        .V_BP     (3),
        .V_ACTIVE (4),
        .V_FP     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .disp_grey (disp_grey),
        .disp_bars (disp_bars),
        .data      (data),
        .hs_n      (hs_n),
        .vs_n      (vs_n),
        .de        (de)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_stats();
        de_cnt = 0; de_lines = 0; first_de_edge = 0; vs_low = 0;
        bad_idle = 0; grey_bad = 0; px = 0; prev_de = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        edge_n++;
        if (de) begin
            if (!prev_de) begin
                de_lines++;
                px = 0;
                if (first_de_edge == 0) first_de_edge = edge_n;
            end else begin
                px++;
            end
            de_cnt++;
            if (cap_en && de_lines == 1 && px < 640) pix[px] = data;
            if (grey_mode && data !== 16'h8080) grey_bad++;
        end else if (data !== 16'h0000) begin
            bad_idle++;
        end
        if (!vs_n) vs_low++;
        prev_de = de;
    endtask

    initial begin
        clear_stats();
        edge_n = 0; cap_en = 1'b0; grey_mode = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_hs_n", 32'(hs_n), 32'd1);
        check("rst_vs_n", 32'(vs_n), 32'd1);
        check("rst_de",   32'(de),   32'd0);
        check("rst_data", 32'(data), 32'h0);

        rst_n = 1'b1;
        @(negedge clk);
        check("idle_hs_n", 32'(hs_n), 32'd1);

        // Frame 1: colour bars, timing measurements
        disp_bars = 1'b1; cap_en = 1'b1; clear_stats(); edge_n = 0;
        enable = 1'b1;
        tick();
        check("first_hs_n", 32'(hs_n), 32'd0);
        check("first_vs_n", 32'(vs_n), 32'd0);
        check("first_de",   32'(de),   32'd0);

        n = 0;
        while (!hs_n && n < 2000) begin tick(); n++; end
        check("hs_rise_edge", 32'(edge_n), 32'd63);
        n = 0;
        while (hs_n && n < 2000) begin tick(); n++; end
        check("hs_fall_edge", 32'(edge_n), 32'd859);

        while (edge_n < 9438) tick();
        check("vs_n_frame_end",  32'(vs_n),          32'd1);
        check("vs_low_clocks",   32'(vs_low),        32'd1716);
        check("de_lines",        32'(de_lines),      32'd4);
        check("de_clocks",       32'(de_cnt),        32'd2560);
        check("first_de_edge",   32'(first_de_edge), 32'd4413);
        check("idle_data_zero",  32'(bad_idle),      32'd0);
        check("bar_px0",   32'(pix[0]),   32'hEB80);
        check("bar_px1",   32'(pix[1]),   32'hEB80);
        check("bar_px80",  32'(pix[80]),  32'hD210);
        check("bar_px81",  32'(pix[81]),  32'hD292);
        check("bar_px200", 32'(pix[200]), 32'hAAA6);
        check("bar_px639", 32'(pix[639]), 32'h1080);
        cap_en = 1'b0;

        tick();
        check("vs_fall_frame2", 32'(vs_n), 32'd0);

        // Frame 2: grey, then bars raised mid-line
        disp_bars = 1'b0; disp_grey = 1'b1; grey_mode = 1'b1; clear_stats();
        n = 0;
        while (!(de && de_lines == 2 && px == 199) && n < 20000) begin tick(); n++; end
        check("grey_de_clocks", 32'(de_cnt),   32'd840);
        check("grey_pixels",    32'(grey_bad), 32'd0);
        check("grey_idle_zero", 32'(bad_idle), 32'd0);

        grey_mode = 1'b0; disp_bars = 1'b1;
        tick();
        check("switch_px200", 32'(data), 32'hAAA6);
        tick();
        check("switch_px201", 32'(data), 32'hAA10);
        n = 0;
        while (de && n < 1000) begin tick(); n++; end
        check("line_end_edge", 32'(edge_n), 32'd15349);
        check("line_last_px",  32'(px),     32'd639);

        // Enable drop mid-line and restart
        n = 0;
        while (!de && n < 2000) begin tick(); n++; end
        repeat (10) tick();
        enable = 1'b0;
        tick();
        check("drop_hs_n", 32'(hs_n), 32'd1);
        check("drop_vs_n", 32'(vs_n), 32'd1);
        check("drop_de",   32'(de),   32'd0);
        check("drop_data", 32'(data), 32'h0);
        tick();
        clear_stats(); edge_n = 0;
        enable = 1'b1;
        tick();
        check("reen_vs_n", 32'(vs_n), 32'd0);
        check("reen_hs_n", 32'(hs_n), 32'd0);

        n = 0;
        while (!de && n < 10000) begin tick(); n++; end
        check("reen_de_edge", 32'(edge_n), 32'd4413);
        check("reen_de",      32'(de),     32'd1);

        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        check("async_de",   32'(de),   32'd0);
        check("async_data", 32'(data), 32'h0);
        check("async_hs_n", 32'(hs_n), 32'd1);
        check("async_vs_n", 32'(vs_n), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
